// File: rtl/relu_stream_sched.sv
// ReLU scheduler: reads a channel-major conv frame from a 1-cycle-latency buffer,
// clamps negatives to zero and streams tagged words through a 2-deep skid buffer.
module relu_stream_sched #(
  parameter int DATA_W    = 33,
  parameter int FMAP_SIZE = 121,
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 9,
  parameter int CNT_W     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [2:0]               out_ch,
  output logic [6:0]               out_idx,
  output logic                     out_last,
  output logic [CNT_W-1:0]         neg_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        ch;
    logic [6:0]        idx;
    logic              last;
  } entry_t;

  state_e            state_q, state_d;
  logic [2:0]        ch_q, ch_d;
  logic [6:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              inflight_q, inflight_d;
  logic [2:0]        if_ch_q, if_ch_d;
  logic [6:0]        if_idx_q, if_idx_d;
  logic              if_last_q, if_last_d;
  entry_t            slot0_q, slot0_d;
  entry_t            slot1_q, slot1_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  neg_q, neg_d;

  logic       accept;
  logic       pop;
  logic [1:0] occ_eff;
  logic [1:0] credit;
  logic       at_idx_end;
  logic       at_ch_end;
  logic       rd_last;
  entry_t     in_e;

  // Occupancy is taken after this cycle's transfer, so a word leaving the
  // buffer frees its slot for a read issued in the same cycle (1 word/cycle).
  always_comb begin
    accept     = (state_q == S_IDLE) && start;
    out_valid  = (occ_q != 2'd0);
    pop        = out_valid && out_ready;
    occ_eff    = occ_q - {1'b0, pop};
    credit     = occ_eff + {1'b0, inflight_q};
    rd_en      = (state_q == S_RUN) && (credit < 2'd2);
    at_idx_end = (idx_q == 7'(FMAP_SIZE - 1));
    at_ch_end  = (ch_q == 3'(NUM_CH - 1));
    rd_last    = at_idx_end && at_ch_end;
    rd_addr    = rd_en ? addr_q : last_addr_q;
    busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    out_data   = slot0_q.data;
    out_ch     = slot0_q.ch;
    out_idx    = slot0_q.idx;
    out_last   = slot0_q.last;
    neg_count  = neg_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (rd_en && rd_last) state_d = S_DRAIN;
      S_DRAIN: if ((occ_eff == 2'd0) && !inflight_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_d        = ch_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    inflight_d  = rd_en;
    if_ch_d     = if_ch_q;
    if_idx_d    = if_idx_q;
    if_last_d   = if_last_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    occ_d       = occ_q;
    neg_d       = neg_q;

    in_e.data = rd_data[DATA_W-1] ? '0 : rd_data;
    in_e.ch   = if_ch_q;
    in_e.idx  = if_idx_q;
    in_e.last = if_last_q;

    if (accept) begin
      ch_d   = '0;
      idx_d  = '0;
      addr_d = '0;
      neg_d  = '0;
    end else if (rd_en) begin
      if_ch_d     = ch_q;
      if_idx_d    = idx_q;
      if_last_d   = rd_last;
      last_addr_d = addr_q;
      addr_d      = addr_q + ADDR_W'(1);
      if (at_idx_end) begin
        idx_d = '0;
        ch_d  = ch_q + 3'd1;
      end else begin
        idx_d = idx_q + 7'd1;
      end
    end

    if (inflight_q && rd_data[DATA_W-1] && (neg_q != '1)) neg_d = neg_q + CNT_W'(1);

    unique case (occ_q)
      2'd0: begin
        if (inflight_q) begin
          slot0_d = in_e;
          occ_d   = 2'd1;
        end
      end
      2'd1: begin
        if (pop && inflight_q) begin
          slot0_d = in_e;
        end else if (pop) begin
          occ_d = 2'd0;
        end else if (inflight_q) begin
          slot1_d = in_e;
          occ_d   = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          slot0_d = slot1_q;
          occ_d   = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      if_ch_q     <= '0;
      if_idx_q    <= '0;
      if_last_q   <= 1'b0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      occ_q       <= '0;
      neg_q       <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      if_ch_q     <= if_ch_d;
      if_idx_q    <= if_idx_d;
      if_last_q   <= if_last_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      occ_q       <= occ_d;
      neg_q       <= neg_d;
    end
  end

endmodule
